// File: rtl/cache_pkg.sv
// cache_pkg: shared widths and fill FSM state encoding for the cache fill path
package cache_pkg;
  localparam int INDEX_W = 10;
  localparam int BEAT_W = 128;
  localparam int LINE_W = 512;
  localparam int NUM_QUARTERS = 4;
  typedef enum logic [1:0] {IDLE, FILL, FLUSH, DONE} fill_state_e;
endpackage

// File: rtl/cache_fill_unit.sv
// cache_fill_unit: assembles 4-beat line fills and store-hit quarter writes into four quarter data banks
module cache_fill_unit
  import cache_pkg::*;
#(
  parameter int INDEX_W = cache_pkg::INDEX_W,
  parameter int BEAT_W = cache_pkg::BEAT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fill_req_valid,
  output logic                  fill_req_ready,
  input  logic [INDEX_W-1:0]    fill_req_index,
  input  logic [1:0]            fill_req_way,
  input  logic                  mem_beat_valid,
  input  logic [BEAT_W-1:0]     mem_beat_data,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [INDEX_W-1:0]    st_index,
  input  logic [1:0]            st_way,
  input  logic [1:0]            st_quarter,
  input  logic [BEAT_W-1:0]     st_data,
  output logic [3:0]            bram_wr_en,
  output logic [INDEX_W+1:0]    bram_wr_addr,
  output logic [BEAT_W-1:0]     bram_wr_data,
  output logic                  fill_done,
  output logic [4*BEAT_W-1:0]   fill_line,
  output logic                  busy
);
  fill_state_e state, state_n;
  logic [1:0] cnt;
  logic [INDEX_W-1:0] idx_q;
  logic [1:0] way_q;
  logic fill_acc, beat_acc, st_acc;
  assign fill_req_ready = state == IDLE;
  assign st_ready = state == IDLE && !fill_req_valid;
  assign fill_acc = fill_req_valid && fill_req_ready;
  assign beat_acc = state == FILL && mem_beat_valid;
  assign st_acc = st_valid && st_ready;
  assign fill_done = state == DONE;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = fill_acc ? FILL : IDLE;
      FILL:    state_n = beat_acc && cnt == 2'd3 ? FLUSH : FILL;
      FLUSH:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      idx_q <= '0;
      way_q <= '0;
      bram_wr_en <= '0;
      bram_wr_addr <= '0;
      bram_wr_data <= '0;
      fill_line <= '0;
    end else begin
      state <= state_n;
      bram_wr_en <= beat_acc ? 4'b0001 << cnt : st_acc ? 4'b0001 << st_quarter : 4'b0000;
      if (beat_acc) begin
        bram_wr_addr <= {idx_q, way_q};
        bram_wr_data <= mem_beat_data;
        cnt <= cnt + 2'd1;
      end else if (st_acc) begin
        bram_wr_addr <= {st_index, st_way};
        bram_wr_data <= st_data;
      end
      if (fill_acc) begin
        idx_q <= fill_req_index;
        way_q <= fill_req_way;
        cnt <= '0;
      end
      for (int q = 0; q < NUM_QUARTERS; q++)
        if (beat_acc && cnt == 2'(q)) fill_line[q*BEAT_W +: BEAT_W] <= mem_beat_data;
    end
  end
endmodule

// File: tb/tb_cache_fill_unit.sv
// tb_cache_fill_unit: directed checks of fills, stores, arbitration and reset for cache_fill_unit
module tb_cache_fill_unit;
  logic clk = 0, rst_n = 0;
  logic fill_req_valid = 0, fill_req_ready;
  logic [9:0] fill_req_index = 0;
  logic [1:0] fill_req_way = 0;
  logic mem_beat_valid = 0;
  logic [127:0] mem_beat_data = 0;
  logic st_valid = 0, st_ready;
  logic [9:0] st_index = 0;
  logic [1:0] st_way = 0, st_quarter = 0;
  logic [127:0] st_data = 0;
  logic [3:0] bram_wr_en;
  logic [11:0] bram_wr_addr;
  logic [127:0] bram_wr_data;
  logic fill_done, busy;
  logic [511:0] fill_line;
  int checks = 0, errors = 0;

  cache_fill_unit dut (
    .clk(clk), .rst_n(rst_n),
    .fill_req_valid(fill_req_valid), .fill_req_ready(fill_req_ready),
    .fill_req_index(fill_req_index), .fill_req_way(fill_req_way),
    .mem_beat_valid(mem_beat_valid), .mem_beat_data(mem_beat_data),
    .st_valid(st_valid), .st_ready(st_ready), .st_index(st_index), .st_way(st_way),
    .st_quarter(st_quarter), .st_data(st_data),
    .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data),
    .fill_done(fill_done), .fill_line(fill_line), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] beat(input logic [7:0] tag, input int i);
    return {4{tag, 24'h000000 | 24'(i)}};
  endfunction

  task automatic start_fill(input logic [9:0] idx, input logic [1:0] way);
    fill_req_valid = 1; fill_req_index = idx; fill_req_way = way;
    tick();
    fill_req_valid = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #1;
    checks++; if (bram_wr_en !== 4'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0000", bram_wr_en); end
    checks++; if (bram_wr_addr !== 12'h0 || bram_wr_data !== 128'h0) begin errors++; $display("FAIL reset_addr_data got=%h/%h exp=0/0", bram_wr_addr, bram_wr_data); end
    checks++; if (fill_done !== 1'b0 || busy !== 1'b0 || fill_line !== 512'h0) begin errors++; $display("FAIL reset_status got done=%b busy=%b line_nz=%b exp 0/0/0", fill_done, busy, |fill_line); end
    tick(); tick();
    rst_n = 1;
    tick();
    checks++; if (fill_req_ready !== 1'b1 || st_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b%b exp=11", fill_req_ready, st_ready); end
  endtask

  task automatic test_fill_consecutive();
    logic [511:0] exp_line;
    start_fill(10'h155, 2'd2);
    checks++; if (busy !== 1'b1 || fill_req_ready !== 1'b0) begin errors++; $display("FAIL fill_busy got busy=%b ready=%b exp 1/0", busy, fill_req_ready); end
    for (int i = 0; i < 4; i++) begin
      mem_beat_valid = 1; mem_beat_data = beat(8'hA0, i);
      exp_line[i*128 +: 128] = beat(8'hA0, i);
      tick();
      checks++; if (bram_wr_en !== 4'(1 << i)) begin errors++; $display("FAIL fill_wr_en%0d got=%b exp=%b", i, bram_wr_en, 4'(1 << i)); end
      checks++; if (bram_wr_addr !== 12'h556 || bram_wr_data !== beat(8'hA0, i)) begin errors++; $display("FAIL fill_wr%0d got addr=%h data=%h exp addr=556 data=%h", i, bram_wr_addr, bram_wr_data, beat(8'hA0, i)); end
      checks++; if (fill_done !== 1'b0) begin errors++; $display("FAIL fill_early_done%0d got=%b exp=0", i, fill_done); end
    end
    mem_beat_valid = 0;
    tick();
    checks++; if (fill_done !== 1'b1 || bram_wr_en !== 4'b0) begin errors++; $display("FAIL fill_done got done=%b wr_en=%b exp 1/0000", fill_done, bram_wr_en); end
    checks++; if (fill_line !== exp_line) begin errors++; $display("FAIL fill_line got=%h exp=%h", fill_line, exp_line); end
    tick();
    checks++; if (fill_done !== 1'b0 || busy !== 1'b0 || fill_req_ready !== 1'b1) begin errors++; $display("FAIL fill_end got done=%b busy=%b ready=%b exp 0/0/1", fill_done, busy, fill_req_ready); end
  endtask

  task automatic test_fill_gaps();
    start_fill(10'h2AA, 2'd1);
    for (int i = 0; i < 4; i++) begin
      mem_beat_valid = 1; mem_beat_data = beat(8'hB0, i);
      tick();
      mem_beat_valid = 0;
      checks++; if (bram_wr_en !== 4'(1 << i) || bram_wr_addr !== 12'hAA9 || bram_wr_data !== beat(8'hB0, i)) begin errors++; $display("FAIL gap_wr%0d got en=%b addr=%h exp en=%b addr=aa9", i, bram_wr_en, bram_wr_addr, 4'(1 << i)); end
      if (i < 3) for (int g = 0; g < 2; g++) begin
        tick();
        checks++; if (bram_wr_en !== 4'b0 || fill_done !== 1'b0) begin errors++; $display("FAIL gap_idle%0d_%0d got en=%b done=%b exp 0000/0", i, g, bram_wr_en, fill_done); end
      end
    end
    tick();
    checks++; if (fill_done !== 1'b1 || bram_wr_en !== 4'b0) begin errors++; $display("FAIL gap_done got done=%b en=%b exp 1/0000", fill_done, bram_wr_en); end
    checks++; if (fill_line[383:256] !== beat(8'hB0, 2)) begin errors++; $display("FAIL gap_line_q2 got=%h exp=%h", fill_line[383:256], beat(8'hB0, 2)); end
    tick();
  endtask

  task automatic test_store_conflict();
    logic [511:0] line_before;
    fill_req_valid = 1; fill_req_index = 10'h0F0; fill_req_way = 2'd0;
    st_valid = 1; st_index = 10'h3FF; st_way = 2'd3; st_quarter = 2'd1; st_data = 128'hDEAD;
    #1;
    checks++; if (st_ready !== 1'b0 || fill_req_ready !== 1'b1) begin errors++; $display("FAIL arb_ready got st=%b fill=%b exp 0/1", st_ready, fill_req_ready); end
    tick();
    fill_req_valid = 0;
    checks++; if (bram_wr_en !== 4'b0 || st_ready !== 1'b0) begin errors++; $display("FAIL arb_no_store got en=%b st_ready=%b exp 0000/0", bram_wr_en, st_ready); end
    for (int i = 0; i < 4; i++) begin
      mem_beat_valid = 1; mem_beat_data = beat(8'hC0, i);
      tick();
    end
    mem_beat_valid = 0;
    tick();
    checks++; if (fill_done !== 1'b1 || st_ready !== 1'b0) begin errors++; $display("FAIL arb_done got done=%b st_ready=%b exp 1/0", fill_done, st_ready); end
    line_before = fill_line;
    tick();
    checks++; if (st_ready !== 1'b1 || bram_wr_en !== 4'b0) begin errors++; $display("FAIL arb_idle got st_ready=%b en=%b exp 1/0000", st_ready, bram_wr_en); end
    tick();
    st_valid = 0;
    checks++; if (bram_wr_en !== 4'b0010 || bram_wr_addr !== 12'hFFF || bram_wr_data !== 128'hDEAD) begin errors++; $display("FAIL store_wr got en=%b addr=%h data=%h exp 0010/fff/dead", bram_wr_en, bram_wr_addr, bram_wr_data); end
    tick();
    checks++; if (bram_wr_en !== 4'b0 || fill_line !== line_before) begin errors++; $display("FAIL store_after got en=%b line_kept=%b exp 0000/1", bram_wr_en, fill_line === line_before); end
  endtask

  task automatic test_store_q3();
    st_valid = 1; st_index = 10'h001; st_way = 2'd0; st_quarter = 2'd3; st_data = 128'h1234_5678;
    tick();
    st_valid = 0;
    checks++; if (bram_wr_en !== 4'b1000 || bram_wr_addr !== 12'h004 || bram_wr_data !== 128'h1234_5678) begin errors++; $display("FAIL store_q3 got en=%b addr=%h data=%h exp 1000/004/12345678", bram_wr_en, bram_wr_addr, bram_wr_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL store_busy got=%b exp=0", busy); end
    tick();
  endtask

  task automatic test_reset_mid_fill();
    start_fill(10'h011, 2'd1);
    for (int i = 0; i < 2; i++) begin
      mem_beat_valid = 1; mem_beat_data = beat(8'hD0, i);
      tick();
    end
    checks++; if (bram_wr_en !== 4'b0010) begin errors++; $display("FAIL rst_mid_pre got=%b exp=0010", bram_wr_en); end
    rst_n = 0;
    #1;
    checks++; if (bram_wr_en !== 4'b0 || bram_wr_addr !== 12'h0 || bram_wr_data !== 128'h0 || fill_line !== 512'h0 || busy !== 1'b0 || fill_done !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs got en=%b addr=%h busy=%b done=%b exp all 0", bram_wr_en, bram_wr_addr, busy, fill_done); end
    tick();
    rst_n = 1;
    #1;
    checks++; if (fill_req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", fill_req_ready); end
    for (int i = 2; i < 6; i++) begin
      mem_beat_data = beat(8'hD0, i);
      tick();
      checks++; if (bram_wr_en !== 4'b0 || fill_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_after%0d got en=%b done=%b busy=%b exp 0000/0/0", i, bram_wr_en, fill_done, busy); end
    end
    mem_beat_valid = 0;
  endtask

  task automatic test_idle_beat();
    for (int i = 0; i < 3; i++) begin
      mem_beat_valid = (i != 1); mem_beat_data = beat(8'hE0, i);
      tick();
      checks++; if (bram_wr_en !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_beat%0d got en=%b busy=%b exp 0000/0", i, bram_wr_en, busy); end
    end
    mem_beat_valid = 0;
  endtask

  initial begin
    test_reset();
    test_fill_consecutive();
    test_fill_gaps();
    test_store_conflict();
    test_store_q3();
    test_reset_mid_fill();
    test_idle_beat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
